// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
// Optional abort port is enabled by defining SERIAL_ADDSUB_ABORT_EN.
package serial_addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seqState_t;

  // Counter width for a WIDTH-bit operation; never narrower than one bit.
  function automatic int cntWidth(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_full_adder.sv
// One-bit full adder cell, time-shared by the serial sequencer.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Y,
  output logic Cout
);

  assign Y    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract/negate sequencer: one full adder, WIDTH cycles, LSB first.
// Define SERIAL_ADDSUB_ABORT_EN to add an abort input that drops the current op.
module serial_addsub_seq
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
`ifdef SERIAL_ADDSUB_ABORT_EN
  input  logic             abort,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  seqState_t        state, nextState;
  logic [WIDTH-1:0] aSh, bSh, yReg;
  logic [CNT_W-1:0] cnt;
  logic             carryReg, coutReg, ovfReg;
  logic             faSum, faCout;
  logic             accept, lastBit, abortHit;
  logic [WIDTH-1:0] finalSum;

  full_adder u_fa (
    .A   (aSh[0]),
    .B   (bSh[0]),
    .Cin (carryReg),
    .Y   (faSum),
    .Cout(faCout)
  );

`ifdef SERIAL_ADDSUB_ABORT_EN
  assign abortHit = abort && (state != IDLE);
`else
  assign abortHit = 1'b0;
`endif

  assign accept   = in_valid && in_ready;
  assign lastBit  = (state == RUN) && (cnt == LAST_CNT);
  // aSh doubles as the result register: sum bits fill it from the top as A drains out.
  assign finalSum = {faSum, aSh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nextState = RUN;
      end
      RUN:     if (lastBit) nextState = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (abortHit) nextState = IDLE;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aSh      <= '0;
      bSh      <= '0;
      yReg     <= '0;
      cnt      <= '0;
      carryReg <= 1'b0;
      coutReg  <= 1'b0;
      ovfReg   <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        aSh      <= A;
        bSh      <= B ^ {WIDTH{sub}};
        carryReg <= sub;
        cnt      <= '0;
      end else if (state == RUN && !abortHit) begin
        aSh      <= finalSum;
        bSh      <= {1'b0, bSh[WIDTH-1:1]};
        carryReg <= faCout;
        cnt      <= cnt + CNT_W'(1);
        // Outputs update only on a completed op, so an abort leaves the last result visible.
        if (lastBit) begin
          yReg    <= finalSum;
          coutReg <= faCout;
          ovfReg  <= carryReg ^ faCout;
        end
      end
    end
  end

  assign Y    = yReg;
  assign cout = coutReg;
  assign ovf  = ovfReg;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Directed self-checking bench for serial_addsub_seq (WIDTH=8).
// Abort scenario runs only when SERIAL_ADDSUB_ABORT_EN is defined.
module tb_serial_addsub_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] Y;
  logic             cout;
  logic             ovf;
`ifdef SERIAL_ADDSUB_ABORT_EN
  logic             abort = 1'b0;
`endif

  int assertCount = 0;
  int failCount   = 0;

  serial_addsub_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .sub      (sub),
`ifdef SERIAL_ADDSUB_ABORT_EN
    .abort    (abort),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Y        (Y),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge; returns just after the accept edge.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    A = a; B = b; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = 8'hA5; B = 8'h5A; sub = ~s;   // operands must already be captured
  endtask

  // Counts edges after accept until out_valid, bounded.
  task automatic waitDone(input string tag);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, WIDTH);
  endtask

  task automatic doOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic s, input logic [WIDTH-1:0] expY, input logic expC, input logic expV);
    out_ready = 1'b1;
    check({tag, " in_ready idle"}, in_ready, 1);
    launch(a, b, s);
    check({tag, " in_ready run"}, in_ready, 0);
    waitDone(tag);
    check({tag, " Y"}, Y, expY);
    check({tag, " cout"}, cout, expC);
    check({tag, " ovf"}, ovf, expV);
    tick();
    check({tag, " drained out_valid"}, out_valid, 0);
    check({tag, " drained in_ready"}, in_ready, 1);
    check({tag, " Y held"}, Y, expY);
  endtask

  initial begin
    logic [WIDTH-1:0] heldY;

    #12;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset Y", Y, 0);
    check("reset cout", cout, 0);
    check("reset ovf", ovf, 0);
    rst_n = 1'b1;
    tick();

    doOp("add 05+03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);

    // Reset two cycles into an op discards it and clears the outputs immediately.
    launch(8'h11, 8'h22, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrun rst out_valid", out_valid, 0);
    check("midrun rst in_ready", in_ready, 1);
    check("midrun rst Y", Y, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    doOp("sub 03-05", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0);
    doOp("sub 05-03", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0);
    doOp("neg 80", 8'h00, 8'h80, 1'b1, 8'h80, 1'b0, 1'b1);
    doOp("neg 01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
    doOp("add 7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // Backpressure: DONE holds, in_valid ignored.
    out_ready = 1'b0;
    launch(8'h12, 8'h34, 1'b0);
    waitDone("bp");
    check("bp Y", Y, 8'h46);
    heldY = Y;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; A = 8'h01; B = 8'h01; sub = 1'b0;
      tick();
      check("bp out_valid held", out_valid, 1);
      check("bp Y stable", Y, heldY);
      check("bp in_ready low", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp release out_valid", out_valid, 0);
    check("bp release in_ready", in_ready, 1);
    tick();
    check("bp no extra op", in_ready, 1);
    check("bp Y after drain", Y, 8'h46);

`ifdef SERIAL_ADDSUB_ABORT_EN
    launch(8'h33, 8'h44, 1'b0);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    check("abort Y kept", Y, 8'h46);
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      check("abort no out_valid", out_valid, 0);
    end
    doOp("add FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
`else
    doOp("add FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
